// File: rtl/trace_align_if.sv
// rtl/trace_align_if.sv - issue/completion/flush inputs and retire-record outputs of trace_align
interface trace_align_if #(
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic        i_valid;
  logic        i_ready;
  logic [31:0] i_pc;
  logic [31:0] i_inst;

  logic        c_valid;
  logic        c_rdv;
  logic [4:0]  c_rd;
  logic [31:0] c_data;
  logic        c_pcv;
  logic [31:0] c_pc;

  logic        flush;

  logic        valid;
  logic [31:0] pc;
  logic [31:0] inst;
  logic        rdv;
  logic [4:0]  rd_x;
  logic [31:0] rd_data;
  logic        pcv;
  logic [31:0] pc_x;
  logic [AW:0] count;
  logic        err;

  // Core/testbench side: drives issue, completion and flush; observes records.
  modport master (
    output i_valid, i_pc, i_inst,
    output c_valid, c_rdv, c_rd, c_data, c_pcv, c_pc,
    output flush,
    input  i_ready,
    input  valid, pc, inst, rdv, rd_x, rd_data, pcv, pc_x, count, err
  );

  // Aligner side.
  modport slave (
    input  i_valid, i_pc, i_inst,
    input  c_valid, c_rdv, c_rd, c_data, c_pcv, c_pc,
    input  flush,
    output i_ready,
    output valid, pc, inst, rdv, rd_x, rd_data, pcv, pc_x, count, err
  );
endinterface

// File: rtl/trace_align.sv
// rtl/trace_align.sv - in-order retirement aligner pairing issued instructions with completions (optional TRACE_ALIGN_CHECK_EN destination check)
module trace_align #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  trace_align_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [31:0] pc_mem   [DEPTH];
  logic [31:0] inst_mem [DEPTH];

  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW:0]   count_q, count_d;
  logic          err_q, err_d;

  logic          valid_q, valid_d;
  logic [31:0]   pc_q, pc_d;
  logic [31:0]   inst_q, inst_d;
  logic          rdv_q, rdv_d;
  logic [4:0]    rd_x_q, rd_x_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          pcv_q, pcv_d;
  logic [31:0]   pc_x_q, pc_x_d;

  logic          empty, full;
  logic          pop, bypass, underflow, push, emit, mem_we;
  logic [31:0]   rec_pc, rec_inst;

  // Classify this cycle's events; an issue meeting a completion on an empty
  // queue is consumed directly instead of being queued.
  always_comb begin
    empty     = (count_q == '0);
    full      = (count_q == FULL_COUNT);
    pop       = bus.c_valid & ~empty;
    bypass    = bus.c_valid & empty & bus.i_valid;
    underflow = bus.c_valid & empty & ~bus.i_valid;
    push      = bus.i_valid & ~full & ~bypass;
    emit      = pop | bypass;
    mem_we    = push & ~bus.flush;
    rec_pc    = pop ? pc_mem[rptr_q]   : bus.i_pc;
    rec_inst  = pop ? inst_mem[rptr_q] : bus.i_inst;
  end

  // Next-state: flush wins over everything; record strobes default low.
  always_comb begin
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    err_d     = err_q;
    valid_d   = 1'b0;
    pc_d      = pc_q;
    inst_d    = inst_q;
    rdv_d     = 1'b0;
    rd_x_d    = rd_x_q;
    rd_data_d = rd_data_q;
    pcv_d     = 1'b0;
    pc_x_d    = pc_x_q;
    if (bus.flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + 1'b1;
      if (pop)  rptr_d = rptr_q + 1'b1;
      if (push && !pop)      count_d = count_q + 1'b1;
      else if (pop && !push) count_d = count_q - 1'b1;
      if (underflow) err_d = 1'b1;
      if (emit) begin
        valid_d   = 1'b1;
        pc_d      = rec_pc;
        inst_d    = rec_inst;
        rdv_d     = bus.c_rdv & (bus.c_rd != 5'd0);
        rd_x_d    = bus.c_rd;
        rd_data_d = bus.c_data;
        pcv_d     = bus.c_pcv;
        pc_x_d    = bus.c_pc;
`ifdef TRACE_ALIGN_CHECK_EN
        if (bus.c_rdv && (bus.c_rd != rec_inst[11:7])) err_d = 1'b1;
`endif
      end
    end
  end

  // Issue queue storage; contents need no reset since count gates every read.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      pc_mem[wptr_q]   <= bus.i_pc;
      inst_mem[wptr_q] <= bus.i_inst;
    end
  end

  // Control state and registered retire record.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      rdv_q     <= 1'b0;
      rd_x_q    <= '0;
      rd_data_q <= '0;
      pcv_q     <= 1'b0;
      pc_x_q    <= '0;
    end else begin
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      err_q     <= err_d;
      valid_q   <= valid_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      rdv_q     <= rdv_d;
      rd_x_q    <= rd_x_d;
      rd_data_q <= rd_data_d;
      pcv_q     <= pcv_d;
      pc_x_q    <= pc_x_d;
    end
  end

  assign bus.i_ready = ~full;
  assign bus.valid   = valid_q;
  assign bus.pc      = pc_q;
  assign bus.inst    = inst_q;
  assign bus.rdv     = rdv_q;
  assign bus.rd_x    = rd_x_q;
  assign bus.rd_data = rd_data_q;
  assign bus.pcv     = pcv_q;
  assign bus.pc_x    = pc_x_q;
  assign bus.count   = count_q;
  assign bus.err     = err_q;
endmodule
